// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divide scheduler: funct3 codes, write-port payload, FSM states.
// Optional feature macro used by div_sched: MDU_DIV0_BYPASS_EN.
package div_sched_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 5;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam logic [DATA_W-1:0]  ZeroWord     = '0;
    localparam logic [RADDR_W-1:0] ZeroReg      = '0;
    localparam logic               WriteEnable  = 1'b1;
    localparam logic               WriteDisable = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_WB    = 2'd3
    } state_e;

    typedef struct packed {
        logic               we;
        logic [RADDR_W-1:0] waddr;
        logic [DATA_W-1:0]  wdata;
    } wb_req_t;

    // Architectural result of a divide by zero: quotient all ones, remainder the dividend.
    function automatic logic [DATA_W-1:0] div0_result(input logic [2:0] op,
                                                      input logic [DATA_W-1:0] dividend);
        logic [DATA_W-1:0] res;
        case (op)
            INST_DIV, INST_DIVU: res = '1;
            INST_REM, INST_REMU: res = dividend;
            default:             res = ZeroWord;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/div_wb_merge.sv
// Register-file write-port mux: EX writeback has priority, the divide write waits for a free slot.
module div_wb_merge
    import div_sched_pkg::*;
(
    input  wb_req_t ex_req,
    input  wb_req_t div_req,
    output wb_req_t reg_req_c,
    output logic    div_ack_c
);

    always_comb begin
        reg_req_c = '{we: WriteDisable, waddr: ZeroReg, wdata: ZeroWord};
        div_ack_c = div_req.we && !ex_req.we;
        if (ex_req.we) begin
            reg_req_c = ex_req;
        end else if (div_req.we) begin
            reg_req_c = div_req;
        end
    end

endmodule

// File: rtl/div_sched.sv
// Sequences the shared multi-cycle divider, holds the pipeline, scoreboards rd, merges the result write.
// Optional: define MDU_DIV0_BYPASS_EN to resolve divide-by-zero without using the divider.
module div_sched
    import div_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    input  logic [2:0]         req_op_i,
    input  logic [DATA_W-1:0]  req_dividend_i,
    input  logic [DATA_W-1:0]  req_divisor_i,
    input  logic [RADDR_W-1:0] req_rd_i,
    output logic               req_ready_o,
    input  logic               flush_i,
    output logic               div_start_o,
    output logic [2:0]         div_op_o,
    output logic [DATA_W-1:0]  div_dividend_o,
    output logic [DATA_W-1:0]  div_divisor_o,
    input  logic               div_done_i,
    input  logic [DATA_W-1:0]  div_result_i,
    input  logic               ex_reg_we_i,
    input  logic [RADDR_W-1:0] ex_reg_waddr_i,
    input  logic [DATA_W-1:0]  ex_reg_wdata_i,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic [DATA_W-1:0]  reg_wdata_o,
    input  logic [RADDR_W-1:0] id_rs1_i,
    input  logic [RADDR_W-1:0] id_rs2_i,
    output logic               hazard_o,
    output logic               hold_o
);

    state_e             state_q, state_d;
    logic [2:0]         op_q;
    logic [DATA_W-1:0]  dividend_q, divisor_q, result_q;
    logic [RADDR_W-1:0] pend_rd_q;
    logic               accept_c, bypass_c, div_ack_c;
    wb_req_t            ex_req_c, div_req_c, reg_req_c;

`ifdef MDU_DIV0_BYPASS_EN
    assign bypass_c = (req_divisor_i == ZeroWord);
`else
    assign bypass_c = 1'b0;
`endif

    assign accept_c = (state_q == S_IDLE) && req_valid_i && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus state-decoded pipeline controls.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        div_start_o = 1'b0;
        hold_o      = 1'b1;
        hazard_o    = (pend_rd_q != ZeroReg) &&
                      ((id_rs1_i == pend_rd_q) || (id_rs2_i == pend_rd_q));
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                hold_o      = 1'b0;
                hazard_o    = 1'b0;
                if (accept_c) begin
                    state_d = bypass_c ? S_WB : S_START;
                end
            end
            S_START: begin
                div_start_o = 1'b1;
                state_d     = flush_i ? S_IDLE : S_BUSY;
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (div_done_i) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                // rd==x0 has nothing to write, so WB lasts a single cycle.
                if (flush_i || (pend_rd_q == ZeroReg) || div_ack_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= 3'b000;
            dividend_q <= ZeroWord;
            divisor_q  <= ZeroWord;
            pend_rd_q  <= ZeroReg;
            result_q   <= ZeroWord;
        end else begin
            if (accept_c) begin
                op_q       <= req_op_i;
                dividend_q <= req_dividend_i;
                divisor_q  <= req_divisor_i;
                pend_rd_q  <= req_rd_i;
`ifdef MDU_DIV0_BYPASS_EN
                if (bypass_c) begin
                    result_q <= div0_result(req_op_i, req_dividend_i);
                end
`endif
            end
            if ((state_q == S_BUSY) && div_done_i && !flush_i) begin
                result_q <= div_result_i;
            end
        end
    end

    assign div_op_o       = op_q;
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;

    assign ex_req_c  = '{we: ex_reg_we_i, waddr: ex_reg_waddr_i, wdata: ex_reg_wdata_i};
    assign div_req_c = '{we:    (state_q == S_WB) && (pend_rd_q != ZeroReg) && !flush_i,
                         waddr: pend_rd_q,
                         wdata: result_q};

    div_wb_merge u_wb_merge (
        .ex_req    (ex_req_c),
        .div_req   (div_req_c),
        .reg_req_c (reg_req_c),
        .div_ack_c (div_ack_c)
    );

    assign reg_we_o    = reg_req_c.we;
    assign reg_waddr_o = reg_req_c.waddr;
    assign reg_wdata_o = reg_req_c.wdata;

endmodule
